// File: rtl/mole_field.sv
// Multi-mole scheduler and scorer: raises up to N_MOLES moles on a divided game tick,
// ages them, and judges hit requests. Define MOLE_PENALTY_EN to make RUN misses cost a point.
module mole_field #(
  parameter int N_HOLES    = 9,
  parameter int N_MOLES    = 3,
  parameter int TICK_DIV   = 12500000,
  parameter int LIFE_TICKS = 8,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inGame,
  input  logic               hit,
  input  logic [3:0]         hit_hole,
  output logic [N_HOLES-1:0] mole_map,
  output logic [SCORE_W-1:0] score,
  output logic               hit_ack,
  output logic               hit_good,
  output logic               running
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       life [N_HOLES];

  logic             tick;
  logic             landed;
  logic             spawn_ok;
  logic [3:0]       cand;
  logic [4:0]       survivors;
  logic [15:0]      map16;

  // A hole is raised exactly while its life counter is non-zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mole_map = '0;
    for (int i = 0; i < N_HOLES; i++) mole_map[i] = (life[i] != 4'd0);
  end

  always_comb begin
    tick      = (state == RUN) && (tick_cnt == CNT_W'(TICK_DIV - 1));
    map16     = 16'(mole_map);
    cand      = lfsr[3:0];
    survivors = '0;
    // Moles still standing after this tick's expiries bound the spawn capacity.
    for (int i = 0; i < N_HOLES; i++)
      if (life[i] > 4'd1) survivors = survivors + 5'd1;
    spawn_ok  = tick && (32'(cand) < N_HOLES) && !map16[cand] && (32'(survivors) < N_MOLES);
    landed    = hit && (state == RUN) && inGame && (32'(hit_hole) < N_HOLES) && map16[hit_hole];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= IDLE;
      lfsr     <= 16'hACE1;
      tick_cnt <= '0;
      score    <= '0;
      hit_ack  <= 1'b0;
      hit_good <= 1'b0;
      running  <= 1'b0;
      // NOTE: the life array is tiny and drives mole_map directly, so it is reset like plain flops.
      for (int i = 0; i < N_HOLES; i++) life[i] <= 4'd0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      hit_ack  <= hit;
      hit_good <= landed;
      case (state)
        IDLE: begin
          if (inGame) begin
            state    <= RUN;
            running  <= 1'b1;
            score    <= '0;
            tick_cnt <= '0;
            for (int i = 0; i < N_HOLES; i++) life[i] <= 4'd0;
          end
        end
        RUN: begin
          if (!inGame) begin
            state   <= IDLE;
            running <= 1'b0;
            for (int i = 0; i < N_HOLES; i++) life[i] <= 4'd0;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            // A landed hit and a spawn never share a hole: one needs it raised, the other empty.
            for (int i = 0; i < N_HOLES; i++) begin
              if (landed && hit_hole == 4'(i))
                life[i] <= 4'd0;
              else if (spawn_ok && cand == 4'(i))
                life[i] <= 4'(LIFE_TICKS);
              else if (tick && life[i] != 4'd0)
                life[i] <= life[i] - 4'd1;
            end
            if (landed) begin
              if (score != '1) score <= score + SCORE_W'(1);
            end
`ifdef MOLE_PENALTY_EN
            else if (hit) begin
              if (score != '0) score <= score - SCORE_W'(1);
            end
`else
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_field.sv
// Self-checking bench for mole_field: randomized play against a mole-list reference model
// plus directed scenarios for lifetime, expiry-hit, saturation, round drop and async reset.
module tb_mole_field;

  localparam int N_HOLES    = 9;
  localparam int N_MOLES    = 3;
  localparam int TICK_DIV   = 4;
  localparam int LIFE_TICKS = 3;
  localparam int SCORE_W    = 3;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               inGame = 1'b0;
  logic               hit = 1'b0;
  logic [3:0]         hit_hole = 4'd0;
  logic [N_HOLES-1:0] mole_map;
  logic [SCORE_W-1:0] score;
  logic               hit_ack;
  logic               hit_good;
  logic               running;

  int checks = 0;
  int errors = 0;

  // Reference model: a list of live moles, each with the tick number on which it drops.
  typedef struct {
    int hole;
    int expire;
  } mole_t;

  mole_t       moles[$];
  bit          m_run;
  int          m_score;
  int          m_cnt;
  int          m_ticks;
  bit [15:0]   m_lfsr;
  bit          e_ack;
  bit          e_good;

  always #5 clk = ~clk;

  mole_field #(
    .N_HOLES(N_HOLES), .N_MOLES(N_MOLES), .TICK_DIV(TICK_DIV),
    .LIFE_TICKS(LIFE_TICKS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .inGame(inGame), .hit(hit), .hit_hole(hit_hole),
    .mole_map(mole_map), .score(score), .hit_ack(hit_ack), .hit_good(hit_good),
    .running(running)
  );

  function automatic bit raised(int h);
    foreach (moles[i]) if (moles[i].hole == h) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N_HOLES-1:0] model_map();
    logic [N_HOLES-1:0] m = '0;
    foreach (moles[i]) m[moles[i].hole] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_score = 0; m_cnt = 0; m_ticks = 0;
    m_lfsr = 16'hACE1; e_ack = 1'b0; e_good = 1'b0;
    moles.delete();
  endtask

  // Applies the current inputs to the model as the coming clock edge will.
  task automatic model_step();
    int cand = int'(m_lfsr[3:0]);
    bit landed = 1'b0;
    e_ack  = hit;
    e_good = 1'b0;
    if (!m_run) begin
      if (inGame) begin
        m_run = 1'b1; m_score = 0; m_cnt = 0; m_ticks = 0;
        moles.delete();
      end
    end else if (!inGame) begin
      m_run = 1'b0;
      moles.delete();
    end else begin
      landed = hit && (hit_hole < N_HOLES) && raised(int'(hit_hole));
      if (m_cnt == TICK_DIV - 1) begin
        int t;
        int alive;
        bit spawn;
        mole_t nm;
        t = m_ticks + 1;
        alive = 0;
        foreach (moles[i]) if (moles[i].expire != t) alive++;
        spawn = (cand < N_HOLES) && !raised(cand) && (alive < N_MOLES);
        for (int i = moles.size() - 1; i >= 0; i--)
          if (moles[i].expire == t) moles.delete(i);
        if (spawn) begin
          nm.hole = cand; nm.expire = t + LIFE_TICKS;
          moles.push_back(nm);
        end
        m_ticks = t;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      if (landed) begin
        for (int i = moles.size() - 1; i >= 0; i--)
          if (moles[i].hole == int'(hit_hole)) moles.delete(i);
        if (m_score < SCORE_MAX) m_score++;
      end
      e_good = landed;
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ensure_run();
    if (!m_run) begin
      inGame = 1'b1;
      tick_clk();
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (mole_map !== '0) begin errors++; $display("FAIL reset_map got %h want 0", mole_map); end
    if (score !== '0)    begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    if (hit_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", hit_ack); end
    if (hit_good !== 1'b0) begin errors++; $display("FAIL reset_good got %b want 0", hit_good); end
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    rst = 1'b1;
    tick_clk();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL idle_running got %b want 0", running); end
  endtask

  task automatic test_start();
    inGame = 1'b1;
    tick_clk();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
    // No mole may appear before the first tick, TICK_DIV cycles into the round.
    for (int c = 1; c < TICK_DIV; c++) begin
      tick_clk();
      checks++;
      if (mole_map !== '0) begin errors++; $display("FAIL pre_tick_map cyc %0d got %h want 0", c, mole_map); end
    end
    tick_clk();
    checks++;
    if (mole_map !== model_map()) begin
      errors++; $display("FAIL first_tick_map got %h want %h", mole_map, model_map());
    end
  endtask

  task automatic test_random_play(int cycles);
    ensure_run();
    for (int c = 0; c < cycles; c++) begin
      int r = int'($urandom_range(0, 99));
      hit = 1'b0;
      if (r < 2) inGame = !inGame;
      else if (!inGame && r < 30) inGame = 1'b1;
      if (m_run && m_cnt == TICK_DIV - 1 && moles.size() > 0 && r < 50) begin
        hit = 1'b1; hit_hole = 4'(moles[0].hole);
      end else if (r < 25 && moles.size() > 0) begin
        hit = 1'b1; hit_hole = 4'(moles[$urandom_range(0, moles.size() - 1)].hole);
      end else if (r < 40) begin
        hit = 1'b1; hit_hole = 4'($urandom_range(0, 15));
      end
      tick_clk();
      checks += 5;
      if (mole_map !== model_map()) begin errors++; $display("FAIL rand_map cyc %0d got %h want %h", c, mole_map, model_map()); end
      if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL rand_score cyc %0d got %0d want %0d", c, score, m_score); end
      if (hit_ack !== e_ack) begin errors++; $display("FAIL rand_ack cyc %0d got %b want %b", c, hit_ack, e_ack); end
      if (hit_good !== e_good) begin errors++; $display("FAIL rand_good cyc %0d got %b want %b", c, hit_good, e_good); end
      if (running !== m_run) begin errors++; $display("FAIL rand_running cyc %0d got %b want %b", c, running, m_run); end
    end
    hit = 1'b0;
    inGame = 1'b1;
  endtask

  task automatic test_lifetime();
    logic [N_HOLES-1:0] prev;
    logic [N_HOLES-1:0] rise;
    int h = -1;
    int n = 0;
    ensure_run();
    prev = mole_map;
    for (int c = 0; c < 400 && h < 0; c++) begin
      tick_clk();
      rise = mole_map & ~prev;
      prev = mole_map;
      for (int i = N_HOLES - 1; i >= 0; i--) if (rise[i]) h = i;
    end
    checks++;
    if (h < 0) begin
      errors++; $display("FAIL lifetime_spawn got none want a raised mole");
    end else begin
      while (mole_map[h] === 1'b1 && n < 100) begin
        tick_clk();
        n++;
      end
      if (n !== LIFE_TICKS * TICK_DIV) begin
        errors++; $display("FAIL lifetime_cycles hole %0d got %0d want %0d", h, n, LIFE_TICKS * TICK_DIV);
      end
    end
    checks++;
    if (mole_map !== model_map()) begin errors++; $display("FAIL lifetime_map got %h want %h", mole_map, model_map()); end
  endtask

  task automatic test_expiry_hit();
    bit done = 1'b0;
    ensure_run();
    for (int c = 0; c < 2000 && !done; c++) begin
      int h = -1;
      if (m_cnt == TICK_DIV - 1)
        foreach (moles[i]) if (moles[i].expire == m_ticks + 1) h = moles[i].hole;
      if (h >= 0) begin
        int prev = m_score;
        int want = (prev < SCORE_MAX) ? prev + 1 : SCORE_MAX;
        hit = 1'b1; hit_hole = 4'(h);
        tick_clk();
        hit = 1'b0;
        checks += 3;
        if (hit_good !== 1'b1) begin errors++; $display("FAIL expiry_hit_good got %b want 1", hit_good); end
        if (mole_map[h] !== 1'b0) begin errors++; $display("FAIL expiry_hit_bit hole %0d got %b want 0", h, mole_map[h]); end
        if (score !== SCORE_W'(want)) begin errors++; $display("FAIL expiry_hit_score got %0d want %0d", score, want); end
        done = 1'b1;
      end else begin
        tick_clk();
      end
    end
    if (!done) begin
      checks++; errors++; $display("FAIL expiry_hit_search got timeout want an expiring mole");
    end
  endtask

  task automatic test_saturation();
    ensure_run();
    for (int c = 0; c < 800; c++) begin
      hit = 1'b0;
      if (moles.size() > 0) begin
        hit = 1'b1; hit_hole = 4'(moles[0].hole);
      end
      tick_clk();
      checks++;
      if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL sat_score cyc %0d got %0d want %0d", c, score, m_score); end
    end
    hit = 1'b0;
    checks++;
    if (score !== SCORE_W'(SCORE_MAX)) begin errors++; $display("FAIL sat_final got %0d want %0d", score, SCORE_MAX); end
  endtask

  task automatic test_drop_and_idle();
    int held;
    bit ready = 1'b0;
    ensure_run();
    for (int c = 0; c < 1000 && !ready; c++) begin
      if (m_score >= 1 && moles.size() > 0) begin
        ready = 1'b1;
      end else begin
        hit = (moles.size() > 0);
        if (hit) hit_hole = 4'(moles[0].hole);
        tick_clk();
        hit = 1'b0;
      end
    end
    checks++;
    if (!ready) begin errors++; $display("FAIL drop_setup got timeout want score and mole"); end
    held = m_score;
    // Hit a raised hole on the very cycle the round ends: it must be a miss.
    hit = 1'b1; hit_hole = 4'(moles[0].hole); inGame = 1'b0;
    tick_clk();
    hit = 1'b0;
    checks += 5;
    if (hit_ack !== 1'b1) begin errors++; $display("FAIL drop_ack got %b want 1", hit_ack); end
    if (hit_good !== 1'b0) begin errors++; $display("FAIL drop_good got %b want 0", hit_good); end
    if (mole_map !== '0) begin errors++; $display("FAIL drop_map got %h want 0", mole_map); end
    if (score !== SCORE_W'(held)) begin errors++; $display("FAIL drop_score got %0d want %0d", score, held); end
    if (running !== 1'b0) begin errors++; $display("FAIL drop_running got %b want 0", running); end
    hit = 1'b1; hit_hole = 4'd0;
    tick_clk();
    hit = 1'b0;
    checks += 3;
    if (hit_ack !== 1'b1) begin errors++; $display("FAIL idle_hit_ack got %b want 1", hit_ack); end
    if (hit_good !== 1'b0) begin errors++; $display("FAIL idle_hit_good got %b want 0", hit_good); end
    if (score !== SCORE_W'(held)) begin errors++; $display("FAIL idle_hit_score got %0d want %0d", score, held); end
    inGame = 1'b1;
    tick_clk();
    checks += 2;
    if (score !== '0) begin errors++; $display("FAIL restart_score got %0d want 0", score); end
    if (running !== 1'b1) begin errors++; $display("FAIL restart_running got %b want 1", running); end
    hit = 1'b1; hit_hole = 4'd12;
    tick_clk();
    hit = 1'b0;
    checks += 2;
    if (hit_ack !== 1'b1) begin errors++; $display("FAIL bad_hole_ack got %b want 1", hit_ack); end
    if (hit_good !== 1'b0) begin errors++; $display("FAIL bad_hole_good got %b want 0", hit_good); end
  endtask

  task automatic test_async_reset();
    ensure_run();
    repeat (2 * TICK_DIV) tick_clk();
    hit = 1'b1; hit_hole = 4'd3;
    #2;
    rst = 1'b0;
    #1;
    checks += 5;
    if (mole_map !== '0) begin errors++; $display("FAIL areset_map got %h want 0", mole_map); end
    if (score !== '0) begin errors++; $display("FAIL areset_score got %0d want 0", score); end
    if (hit_ack !== 1'b0) begin errors++; $display("FAIL areset_ack got %b want 0", hit_ack); end
    if (hit_good !== 1'b0) begin errors++; $display("FAIL areset_good got %b want 0", hit_good); end
    if (running !== 1'b0) begin errors++; $display("FAIL areset_running got %b want 0", running); end
    @(posedge clk);
    #1;
    checks++;
    if (hit_ack !== 1'b0) begin errors++; $display("FAIL areset_no_ack got %b want 0", hit_ack); end
    hit = 1'b0;
    inGame = 1'b0;
    model_reset();
    rst = 1'b1;
    tick_clk();
  endtask

  initial begin
    test_reset();
    test_start();
    test_random_play(600);
    test_lifetime();
    test_expiry_hit();
    test_saturation();
    test_drop_and_idle();
    test_async_reset();
    test_random_play(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_field.md
# mole_field

Parametrised mole scheduler and scorer for the whack-a-mole game. It keeps up to N_MOLES moles raised across N_HOLES holes, ages each mole on a divided game tick, and judges hit requests against the live mole map. It keeps a saturating score. It sits between the player input and the VGA/seven-segment outputs and replaces the single-position random generator with a multi-mole, lifetime-aware field.

## Interface
Parameters:
- N_HOLES, default 9: number of holes, range 2..16.
- N_MOLES, default 3: maximum moles raised at once, range 1..N_HOLES.
- TICK_DIV, default 12500000: clk cycles per game tick, minimum 2.
- LIFE_TICKS, default 8: ticks a mole stays raised, range 1..15.
- SCORE_W, default 8: score width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- inGame  in  1  level; high means a round is running.
- hit  in  1  one-cycle hit request strobe.
- hit_hole  in  4  hole index of the request, sampled when hit=1.
- mole_map  out  N_HOLES  bit i=1 means a mole is raised in hole i.
- score  out  SCORE_W  current score.
- hit_ack  out  1  one-cycle pulse answering every hit.
- hit_good  out  1  one-cycle pulse, coincident with hit_ack, when the hit landed.
- running  out  1  high in state RUN.

## Operation
- States:
  - IDLE: reset state. On inGame=1 go to RUN; that transition clears score, mole_map, all life counters and the tick counter.
  - RUN: on inGame=0 go to IDLE, clearing mole_map and life counters. Score is held for display.
- Tick: the counter runs 0..TICK_DIV-1 in RUN only and emits an internal tick when it reaches TICK_DIV-1.
- Each hole has a 4-bit life counter. On a tick:
  - Every raised hole decrements its counter.
  - A hole whose counter is 1 before the tick is lowered.
- Spawn, on the same tick: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advances every clk cycle in any state. Candidate = lfsr[3:0]. A mole spawns with life LIFE_TICKS only if all three hold:
  - candidate < N_HOLES;
  - the candidate hole is empty in the pre-tick map;
  - popcount(pre-tick map) minus the moles expiring this tick < N_MOLES.
  
  Otherwise there is no spawn that tick. There is no retry.
- Hit, in RUN with hit=1:
  - If hit_hole < N_HOLES and mole_map[hit_hole]=1: lower that mole, score+1 saturating at 2^SCORE_W-1, hit_good=1.
  - Otherwise it is a miss and the score is unchanged.
  - In IDLE a hit is always a miss, and hit_ack is still produced.
- Simultaneous events on the same cycle:
  - Hit and expiry on the same hole: the hit counts and the hole is lowered.
  - Hit on hole h and a spawn candidate of h: the spawn uses the pre-hit map, so it is suppressed if h was raised.
  - Hit and inGame falling: the hit is judged as a miss and the transition to IDLE proceeds.
- Reset (async, any time): state IDLE, mole_map=0, score=0, hit_ack=0, hit_good=0, running=0, LFSR=16'hACE1, counters 0.

## Timing
- hit_ack and hit_good are registered: they are high in cycle t+1 for a hit in cycle t. Back-to-back hits each get their own ack.
- mole_map updates in the cycle after the tick pulse. It updates in the cycle after the hit for a landed hit.
- score updates in the same cycle as hit_good.
- running goes high one cycle after inGame is sampled high. The first tick comes TICK_DIV cycles after RUN is entered.
- A mole raised at tick k is lowered at tick k+LIFE_TICKS unless it is hit first.
- inGame is assumed synchronous to clk; it is synchronised upstream.

## Configuration
- MOLE_PENALTY_EN defined: a miss while in RUN decrements score, saturating at 0. IDLE misses never penalise.
- MOLE_PENALTY_EN undefined: misses never change score.

## Test plan
- Reset with TICK_DIV=4 → all outputs 0; after inGame=1, running=1 one cycle later; the first mole appears only after 4 cycles and only on a qualifying LFSR value, matching a reference LFSR model.
- N_MOLES=1, LIFE_TICKS=2: hit on the raised hole → hit_ack=1 and hit_good=1 at t+1, score 0→1, bit cleared. Hit on an empty hole → hit_ack=1, hit_good=0, score unchanged.
- Leave a mole unhit with LIFE_TICKS=3 → it is lowered exactly 3 ticks after spawn. Hit it on its expiry tick → score+1.
- SCORE_W=2: four landed hits → score sticks at 3. With MOLE_PENALTY_EN, at score 0 a miss holds 0; at score 2 a miss gives 1.
- Drop inGame with 3 moles up and score 5 → mole_map=0 next cycle, score stays 5. Raise inGame again → score resets to 0.
- Assert rst low mid-round with an ack pending → all outputs 0 immediately, no ack emitted, LFSR restarts at ACE1.
